// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised multi-read-port register file with per-entry busy
// scoreboard, same-cycle write-to-read bypass, optional hard-wired zero r0 and
// a self-initialising fill sequence that runs after reset or on init_req.
//
// Ports
//   clk       clock, rising edge
//   reset     asynchronous active-low reset
//   rd_addr   NUM_RD packed read addresses, port k = [k*ADDR_W +: ADDR_W]
//   rd_data   NUM_RD packed read data,      port k = [k*DATA_W +: DATA_W]
//   rd_busy   per read port: addressed register has a pending write
//   wr_en     write strobe (also clears busy of wr_addr)
//   wr_addr   write address
//   wr_data   write data
//   rsv_en    reserve strobe (sets busy of rsv_addr)
//   rsv_addr  register being reserved
//   init_req  one-cycle pulse restarting the fill sequence
//   ready     file is in RUN and accepts reads/writes/reserves

// One combinational read port: priority mux over not-ready / zero-r0 /
// bypass / array, plus the bypass-aware busy flag.
module reg_file_sb_rd_port #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic              ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [DATA_W-1:0] array_data,
    input  logic              array_busy,
    output logic [DATA_W-1:0] data,
    output logic              busy
);
    logic fwd;
    logic zero;

    always_comb begin
        fwd  = BYPASS && wr_en && (wr_addr == addr);
        zero = ZERO_R0 && (addr == '0);
        data = '0;
        busy = 1'b0;
        if (ready) begin
            if (zero)     data = '0;
            else if (fwd) data = wr_data;
            else          data = array_data;
            // forwarded data is final unless the same register is being
            // re-reserved in this very cycle
            busy = array_busy && (!fwd || (rsv_en && (rsv_addr == addr)));
        end
    end
endmodule

module reg_file_sb #(
    parameter int                DATA_W   = 64,
    parameter int                ADDR_W   = 5,
    parameter int                NUM_RD   = 2,
    parameter bit                ZERO_R0  = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(1),
    parameter bit                BYPASS   = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    input  logic                       init_req,
    output logic                       ready
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    state_t                          state, state_nxt;
    logic   [ADDR_W-1:0]             cnt;
    logic   [DEPTH-1:0]              busy;
    logic   [DATA_W-1:0]             mem [DEPTH];
    logic                            init_we;
    logic                            run_ok;
    logic                            wr_ok;

    logic [NUM_RD-1:0][ADDR_W-1:0]   ra;
    logic [NUM_RD-1:0][DATA_W-1:0]   rd;
    logic [NUM_RD-1:0][DATA_W-1:0]   arr_data;
    logic [NUM_RD-1:0]               arr_busy;

    assign ra      = rd_addr;
    assign rd_data = rd;

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_INIT;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (cnt == '1) state_nxt = S_RUN;
            S_RUN:   if (init_req)  state_nxt = S_INIT;
            default: state_nxt = S_INIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready   = (state == S_RUN);
        init_we = (state == S_INIT);
    end

    // writes/reserves are dropped in the cycle that restarts the fill
    assign run_ok = ready && !init_req;
    assign wr_ok  = run_ok && wr_en && !(ZERO_R0 && (wr_addr == '0));

    // fill counter wraps back to 0 on the last entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             cnt <= '0;
        else if (init_we)       cnt <= cnt + ADDR_W'(1);
        else if (init_req)      cnt <= '0;
    end

    // storage is not reset; the fill sequence owns initialisation
    always_ff @(posedge clk) begin
        if (init_we)    mem[cnt]     <= INIT_VAL;
        else if (wr_ok) mem[wr_addr] <= wr_data;
    end

    // scoreboard: reserve beats write-clear on the same register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else if (!run_ok) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rsv_en && (rsv_addr == ADDR_W'(i)))     busy[i] <= 1'b1;
                else if (wr_en && (wr_addr == ADDR_W'(i)))  busy[i] <= 1'b0;
            end
            if (ZERO_R0) busy[0] <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign arr_data[k] = mem[ra[k]];
        assign arr_busy[k] = busy[ra[k]];

        reg_file_sb_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_R0 (ZERO_R0),
            .BYPASS  (BYPASS)
        ) u_port (
            .ready      (ready),
            .addr       (ra[k]),
            .wr_en      (wr_en),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .rsv_en     (rsv_en),
            .rsv_addr   (rsv_addr),
            .array_data (arr_data[k]),
            .array_busy (arr_busy[k]),
            .data       (rd[k]),
            .busy       (rd_busy[k])
        );
    end
endmodule
